// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants and types for the MIPS general-purpose register file.
//   Also used by decode (source register numbers) and writeback (destination
//   register and result data).
package reg_file_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [ADDR_W-1:0] reg_num_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// reg_file_if
//   Bus between the pipeline and the register file.
//   Signals:
//     wr_en    write enable for the write port
//     wp_num   write register number
//     wp_data  write data
//     rpa_num  read port A register number
//     rpb_num  read port B register number
//     rpa_out  read port A data
//     rpb_out  read port B data
//   Modports:
//     master   pipeline side (drives numbers/data, receives read data)
//     slave    register-file side
interface reg_file_if;
   import reg_file_pkg::*;

   logic      wr_en;
   reg_num_t  wp_num;
   reg_data_t wp_data;
   reg_num_t  rpa_num;
   reg_num_t  rpb_num;
   reg_data_t rpa_out;
   reg_data_t rpb_out;

   modport master (
      output wr_en, wp_num, wp_data, rpa_num, rpb_num,
      input  rpa_out, rpb_out
   );

   modport slave (
      input  wr_en, wp_num, wp_data, rpa_num, rpb_num,
      output rpa_out, rpb_out
   );

endinterface : reg_file_if

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
//   One combinational read port: selects a register from the storage array.
//   Optional macro REG_ZERO_HARDWIRED_EN: address 0 always reads as 0 ($zero).
//   Ports:
//     regs  input   full register array
//     num   input   register number to read
//     data  output  selected register contents (0-cycle latency)
module reg_file_rd_port
   import reg_file_pkg::*;
(
   input  reg_data_t regs [NUM_REGS],
   input  reg_num_t  num,
   output reg_data_t data
);

   always_comb begin
`ifdef REG_ZERO_HARDWIRED_EN
      data = (num == '0) ? '0 : regs[num];
`else
      data = regs[num];
`endif
   end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// reg_file
//   32 x 32-bit MIPS general-purpose register file: one clocked write port,
//   two independent combinational read ports (A, B). No write-to-read bypass:
//   a read of the register being written returns the old value until the edge.
//   Optional macro REG_ZERO_HARDWIRED_EN: register 0 is $zero (writes to it are
//   discarded, reads of it return 0); otherwise register 0 is ordinary.
//   Ports:
//     clk  input   rising-edge clock
//     rst  input   synchronous active-high reset, clears every register,
//                  takes priority over a write on the same edge
//     bus  slave   reg_file_if (write port and both read ports)
module reg_file
   import reg_file_pkg::*;
(
   input logic       clk,
   input logic       rst,
   reg_file_if.slave bus
);

   reg_data_t regs [NUM_REGS];
   logic      wr_ok;

   always_comb begin
`ifdef REG_ZERO_HARDWIRED_EN
      wr_ok = bus.wr_en && (bus.wp_num != '0);
`else
      wr_ok = bus.wr_en;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (wr_ok) begin
         regs[bus.wp_num] <= bus.wp_data;
      end
   end

   reg_file_rd_port u_rd_a (
      .regs (regs),
      .num  (bus.rpa_num),
      .data (bus.rpa_out)
   );

   reg_file_rd_port u_rd_b (
      .regs (regs),
      .num  (bus.rpb_num),
      .data (bus.rpb_out)
   );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Scoreboard bench for reg_file. Stimulus drives one cycle at a time
//   (#1 after the rising edge) and, when a read is to be checked, pushes the
//   expected port A/B values; the monitor pops and compares on the falling
//   edge of the same cycle, before the next capturing edge.
module tb_reg_file;
   import reg_file_pkg::*;

`ifdef REG_ZERO_HARDWIRED_EN
   localparam bit ZERO_HW = 1'b1;
`else
   localparam bit ZERO_HW = 1'b0;
`endif

   typedef struct {
      reg_data_t a;
      reg_data_t b;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   reg_file_if bus ();

   reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t  exp_q  [$];
   string name_q [$];
   int    checks   = 0;
   int    failures = 0;

   // Monitor: compare whatever the stimulus expects for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (bus.rpa_out !== e.a) begin
            failures++;
            $display("FAIL %s portA num=%0d got=%h exp=%h", nm, bus.rpa_num, bus.rpa_out, e.a);
         end
         checks++;
         if (bus.rpb_out !== e.b) begin
            failures++;
            $display("FAIL %s portB num=%0d got=%h exp=%h", nm, bus.rpb_num, bus.rpb_out, e.b);
         end
      end
   end

   task automatic step(input bit r, input bit we, input int wn, input reg_data_t wd,
                       input int a, input int b, input bit chk,
                       input reg_data_t ea, input reg_data_t eb, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      bus.wr_en   = we;
      bus.wp_num  = reg_num_t'(wn);
      bus.wp_data = wd;
      bus.rpa_num = reg_num_t'(a);
      bus.rpb_num = reg_num_t'(b);
      if (chk) begin
         e.a = ea;
         e.b = eb;
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   task automatic rd(input int a, input int b, input reg_data_t ea, input reg_data_t eb,
                     input string nm);
      step(1'b0, 1'b0, 0, '0, a, b, 1'b1, ea, eb, nm);
   endtask

   function automatic reg_data_t sweep_val(input int i);
      reg_data_t v;
      if (i == 0) v = ZERO_HW ? 32'h0 : 32'h0000_0077;
      else        v = reg_data_t'(i) * 32'h0101_0101;
      return v;
   endfunction

   initial begin
      reg_data_t r0_exp;
      int        waited;

      bus.wr_en   = 1'b0;
      bus.wp_num  = '0;
      bus.wp_data = '0;
      bus.rpa_num = '0;
      bus.rpb_num = '0;

      // Reset, then every address on both ports reads 0.
      step(1'b1, 1'b0, 0, '0, 0, 0, 1'b0, '0, '0, "");
      for (int i = 0; i < NUM_REGS; i++) rd(i, NUM_REGS - 1 - i, '0, '0, "reset_zero");

      // Enabled writes r0=3, r1=6, r2=9.
      step(1'b0, 1'b1, 0, 32'd3, 0, 0, 1'b0, '0, '0, "");
      step(1'b0, 1'b1, 1, 32'd6, 0, 0, 1'b0, '0, '0, "");
      step(1'b0, 1'b1, 2, 32'd9, 0, 0, 1'b0, '0, '0, "");
      r0_exp = ZERO_HW ? 32'd0 : 32'd3;
      rd(0, 1, r0_exp, 32'd6, "wr_r0_r1");
      rd(2, 2, 32'd9, 32'd9, "wr_r2");

      // Disabled write to r3, enabled write r4=15.
      step(1'b0, 1'b0, 3, 32'd12, 0, 0, 1'b0, '0, '0, "");
      step(1'b0, 1'b1, 4, 32'd15, 0, 0, 1'b0, '0, '0, "");
      rd(3, 4, 32'd0, 32'd15, "disabled_wr");
      rd(5, 5, 32'd0, 32'd0, "unwritten_r5");

      // Same-cycle read/write of r7: old value before the edge, new after.
      step(1'b0, 1'b1, 7, 32'hDEAD_BEEF, 7, 7, 1'b1, 32'd0, 32'd0, "rw_same_pre");
      rd(7, 7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rw_same_post");

      // Reset beats a same-edge write; r1 still 6 until that edge.
      step(1'b1, 1'b1, 1, 32'h55, 1, 2, 1'b1, 32'd6, 32'd9, "rst_pre_edge");
      rd(1, 2, 32'd0, 32'd0, "rst_priority");
      rd(7, 4, 32'd0, 32'd0, "rst_clears");

      // Full sweep.
      step(1'b0, 1'b1, 0, 32'h0000_0077, 0, 0, 1'b0, '0, '0, "");
      for (int i = 1; i < NUM_REGS; i++)
         step(1'b0, 1'b1, i, reg_data_t'(i) * 32'h0101_0101, 0, 0, 1'b0, '0, '0, "");
      for (int i = 0; i < NUM_REGS; i++)
         rd(i, NUM_REGS - 1 - i, sweep_val(i), sweep_val(NUM_REGS - 1 - i), "sweep");

      // Drain the scoreboard with a bounded wait.
      waited = 0;
      while (exp_q.size() > 0 && waited < 8) begin
         @(posedge clk);
         waited++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_reg_file
